regfile_scoreboard: RTL

Parametrised successor to the pipeline register file. It holds `2**ADDR_W` general registers of `DATA_W` bits, with two combinational read ports and one clocked write port. It also keeps a per-register pending-write scoreboard, so the hazard unit can stall on operands whose producer has issued but not yet written back. It sits in the decode stage: reads at ID, issues at ID, writes back from WB.

---
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register file (2**ADDR_W x DATA_W, two comb reads, one write) with per-register pending-write counters.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data and busy-retire onto the read ports.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_A,
    input  logic              FLUSH,
    output logic              ISSUE_OVF
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  pend_q [NREG];
    logic [CNT_W-1:0]  pend_d [NREG];
    logic              ovf_q;
    logic              ovf_d;
    logic              wr_en;
    logic              iss_hit_wb;

    assign wr_en      = WE3 && (A3 != '0);
    assign iss_hit_wb = ISSUE_EN && WE3 && (ISSUE_A == A3);

    always_comb begin
        // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int r = 1; r < NREG; r++) begin
            if (ISSUE_EN && (ISSUE_A == ADDR_W'(r)) && !iss_hit_wb) begin
                if (pend_q[r] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] + 1'b1;
                end
            end else if (WE3 && (A3 == ADDR_W'(r)) && !iss_hit_wb) begin
                if (pend_q[r] != '0) begin
                    pend_d[r] = pend_q[r] - 1'b1;
                end
            end
        end
        // Flush discards this cycle's counter updates but not an overflow detection.
        if (FLUSH) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the data array is reset too, because reading zero after reset is architecturally visible.
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (wr_en) begin
                regs_q[A3] <= WD3;
            end
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              pend1_nz;
    logic              pend2_nz;

    assign stored1  = (A1 == '0) ? '0 : regs_q[A1];
    assign stored2  = (A2 == '0) ? '0 : regs_q[A2];
    assign pend1_nz = (A1 != '0) && (pend_q[A1] != '0);
    assign pend2_nz = (A2 != '0) && (pend_q[A2] != '0);

`ifdef REGFILE_WB_BYPASS_EN
    logic retire_last;

    // The writeback retiring the final in-flight write clears busy in the same cycle.
    assign retire_last = wr_en && (pend_q[A3] == CNT_W'(1)) && !(ISSUE_EN && (ISSUE_A == A3));

    assign RD1   = (wr_en && (A1 == A3)) ? WD3 : stored1;
    assign RD2   = (wr_en && (A2 == A3)) ? WD3 : stored2;
    assign BUSY1 = pend1_nz && !(retire_last && (A1 == A3));
    assign BUSY2 = pend2_nz && !(retire_last && (A2 == A3));
`else
    assign RD1   = stored1;
    assign RD2   = stored2;
    assign BUSY1 = pend1_nz;
    assign BUSY2 = pend2_nz;
`endif

    assign ISSUE_OVF = ovf_q;

endmodule
